// File: rtl/lrck_rate_detector.sv
// Measures the I2S LRCK period in clk cycles, classifies it into rate multiple
// (x1..x8) and base family (44.1k / 48k), and qualifies the result with a lock flag.
module lrck_rate_detector #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int CNT_W    = 16,
  parameter int STABLE_N = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             lrck,
  output logic [1:0]       rate,
  output logic             fam_48,
  output logic             locked,
  output logic             change,
  output logic [CNT_W-1:0] period
);

  localparam int               MC_W     = $clog2(STABLE_N + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [MC_W-1:0]  STABLE_V = MC_W'(STABLE_N);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACQ  = 2'd1,
    S_LOCK = 2'd2
  } state_t;

  // Class index is {rate, fam_48}, so the table runs 44.1k, 48k, 88.2k, ... 384k.
  function automatic logic [31:0] nominal_period(input logic [2:0] idx);
    logic [31:0] p;
    case (idx)
      3'd0:    p = 32'(CLK_HZ / 32'd44100);
      3'd1:    p = 32'(CLK_HZ / 32'd48000);
      3'd2:    p = 32'(CLK_HZ / 32'd88200);
      3'd3:    p = 32'(CLK_HZ / 32'd96000);
      3'd4:    p = 32'(CLK_HZ / 32'd176400);
      3'd5:    p = 32'(CLK_HZ / 32'd192000);
      3'd6:    p = 32'(CLK_HZ / 32'd352800);
      3'd7:    p = 32'(CLK_HZ / 32'd384000);
      default: p = 32'(CLK_HZ / 32'd44100);
    endcase
    return p;
  endfunction

  function automatic logic in_class(input logic [CNT_W-1:0] m, input logic [2:0] idx);
    logic [31:0] p;
    logic [31:0] mv;
    logic [31:0] d;
    p  = nominal_period(idx);
    mv = 32'(m);
    d  = (mv >= p) ? (mv - p) : (p - mv);
    return (d <= (p >> 5));
  endfunction

  logic [1:0]       sync_r;
  logic             sync_prev_r;
  logic             edge_r;
  logic [CNT_W-1:0] cnt_r;
  state_t           state_r;
  logic [MC_W-1:0]  match_cnt_r;
  logic [MC_W-1:0]  miss_cnt_r;
  logic [2:0]       cand_r;

  logic [7:0]       hit_s;
  logic [2:0]       cls_idx_s;
  logic             cls_valid_s;
  logic [2:0]       cand_nxt_s;
  logic [MC_W-1:0]  match_nxt_s;
  logic [MC_W-1:0]  miss_nxt_s;

  // Synchronise lrck, detect its rising edge and count clk cycles between edges
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_r      <= 2'b00;
      sync_prev_r <= 1'b0;
      edge_r      <= 1'b0;
      cnt_r       <= {CNT_W{1'b0}};
    end else begin
      sync_r      <= {sync_r[0], lrck};
      sync_prev_r <= sync_r[1];
      edge_r      <= sync_r[1] & ~sync_prev_r;
      if (edge_r) begin
        cnt_r <= CNT_W'(1'b1);
      end else if (cnt_r != CNT_MAX) begin
        cnt_r <= cnt_r + CNT_W'(1'b1);
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Classes never overlap, so OR-ing the matching indices yields the single hit
  always_comb begin
    hit_s       = 8'd0;
    cls_idx_s   = 3'd0;
    cls_valid_s = 1'b0;
    for (int i = 0; i < 8; i++) begin
      hit_s[i]  = in_class(cnt_r, 3'(i));
      cls_idx_s = cls_idx_s | ({3{hit_s[i]}} & 3'(i));
    end
    cls_valid_s = |hit_s;
  end

  // Next candidate/match count while acquiring and next miss count while locked
  always_comb begin
    cand_nxt_s  = cand_r;
    match_nxt_s = {MC_W{1'b0}};
    miss_nxt_s  = {MC_W{1'b0}};
    if (!cls_valid_s) begin
      match_nxt_s = {MC_W{1'b0}};
    end else if (cls_idx_s == cand_r) begin
      match_nxt_s = match_cnt_r + MC_W'(1'b1);
    end else begin
      cand_nxt_s  = cls_idx_s;
      match_nxt_s = MC_W'(1'b1);
    end
    if (cls_valid_s && (cls_idx_s == {rate, fam_48})) begin
      miss_nxt_s = {MC_W{1'b0}};
    end else begin
      miss_nxt_s = miss_cnt_r + MC_W'(1'b1);
    end
  end

  // Acquire/lock state machine; every output is registered here
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r     <= S_IDLE;
      match_cnt_r <= {MC_W{1'b0}};
      miss_cnt_r  <= {MC_W{1'b0}};
      cand_r      <= 3'd0;
      rate        <= 2'b00;
      fam_48      <= 1'b0;
      locked      <= 1'b0;
      change      <= 1'b0;
      period      <= {CNT_W{1'b0}};
    end else begin
      change <= 1'b0;
      if (edge_r) begin
        case (state_r)
          S_IDLE: begin
            state_r     <= S_ACQ;
            match_cnt_r <= {MC_W{1'b0}};
          end
          S_ACQ: begin
            period      <= cnt_r;
            cand_r      <= cand_nxt_s;
            match_cnt_r <= match_nxt_s;
            if (match_nxt_s == STABLE_V) begin
              state_r    <= S_LOCK;
              rate       <= cand_nxt_s[2:1];
              fam_48     <= cand_nxt_s[0];
              locked     <= 1'b1;
              change     <= 1'b1;
              miss_cnt_r <= {MC_W{1'b0}};
            end else begin
              state_r <= S_ACQ;
            end
          end
          S_LOCK: begin
            period <= cnt_r;
            if (miss_nxt_s == STABLE_V) begin
              state_r     <= S_ACQ;
              locked      <= 1'b0;
              match_cnt_r <= {MC_W{1'b0}};
              miss_cnt_r  <= {MC_W{1'b0}};
            end else begin
              miss_cnt_r <= miss_nxt_s;
            end
          end
          default: begin
            state_r     <= S_IDLE;
            locked      <= 1'b0;
            match_cnt_r <= {MC_W{1'b0}};
            miss_cnt_r  <= {MC_W{1'b0}};
          end
        endcase
      end else if (cnt_r == CNT_MAX) begin
        // LRCK has gone quiet: drop lock but keep the last rate and period visible
        state_r     <= S_IDLE;
        locked      <= 1'b0;
        match_cnt_r <= {MC_W{1'b0}};
        miss_cnt_r  <= {MC_W{1'b0}};
      end else begin
        state_r <= state_r;
      end
    end
  end

endmodule

// File: tb/tb_lrck_rate_detector.sv
// Table-driven bench for lrck_rate_detector: LRCK patterns per step, expected
// lock events queued on a scoreboard and checked on every change pulse.
module tb_lrck_rate_detector;

  logic        clk;
  logic        resetn;
  logic        lrck;
  logic [1:0]  rate;
  logic        fam_48;
  logic        locked;
  logic        change;
  logic [15:0] period;

  lrck_rate_detector #(
    .CLK_HZ  (50_000_000),
    .CNT_W   (16),
    .STABLE_N(4)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .lrck  (lrck),
    .rate  (rate),
    .fam_48(fam_48),
    .locked(locked),
    .change(change),
    .period(period)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         t;
    int         n;
    int         mode;       // 0 constant, 1 alternate t/t+1, 2 jitter +-20, 3 700-cycle glitch on even calls
    logic       push;       // this step is expected to produce a lock entry
    logic       exp_locked;
    logic [1:0] exp_rate;
    logic       exp_fam;
    int         exp_period;
    int         per_tol;
    int         exp_changes;
  } step_t;

  typedef struct {
    logic [1:0] rate;
    logic       fam;
    int         period;
    int         tol;
  } lock_t;

  step_t tbl[16];
  lock_t exp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    n_changes = 0;
  logic  chg_prev = 1'b0;

  task automatic cmp(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cmp_tol(input string name, input int act, input int exp, input int tol);
    n_cmp++;
    if ((act < exp - tol) || (act > exp + tol)) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d +- %0d", name, act, exp, tol);
    end
  endtask

  function automatic step_t mk(input int t, input int n, input int mode, input logic push,
                               input logic lk, input logic [1:0] r, input logic f,
                               input int per, input int tol, input int chg);
    step_t s;
    s.t = t; s.n = n; s.mode = mode; s.push = push;
    s.exp_locked = lk; s.exp_rate = r; s.exp_fam = f;
    s.exp_period = per; s.per_tol = tol; s.exp_changes = chg;
    return s;
  endfunction

  function automatic lock_t mk_lock(input logic [1:0] r, input logic f, input int per, input int tol);
    lock_t l;
    l.rate = r; l.fam = f; l.period = per; l.tol = tol;
    return l;
  endfunction

  // One LRCK frame: rising edge now (at a negedge), t clk cycles until the next frame.
  task automatic lrck_frame(input int t);
    lrck = 1'b1;
    repeat (t / 2) @(negedge clk);
    lrck = 1'b0;
    repeat (t - t / 2) @(negedge clk);
  endtask

  function automatic int frame_len(input step_t s, input int i);
    case (s.mode)
      1:       return s.t + (i % 2);
      2:       return s.t + int'($urandom_range(40)) - 20;
      3:       return ((i % 2) == 0) ? 700 : s.t;
      default: return s.t;
    endcase
  endfunction

  task automatic run_steps(input int lo, input int hi);
    for (int s = lo; s <= hi; s++) begin
      if (tbl[s].push) exp_q.push_back(mk_lock(tbl[s].exp_rate, tbl[s].exp_fam,
                                              tbl[s].exp_period, tbl[s].per_tol));
      for (int i = 0; i < tbl[s].n; i++) lrck_frame(frame_len(tbl[s], i));
      cmp($sformatf("step%0d_locked", s), int'(locked), int'(tbl[s].exp_locked));
      cmp($sformatf("step%0d_rate", s), int'(rate), int'(tbl[s].exp_rate));
      cmp($sformatf("step%0d_fam48", s), int'(fam_48), int'(tbl[s].exp_fam));
      cmp_tol($sformatf("step%0d_period", s), int'(period), tbl[s].exp_period, tbl[s].per_tol);
      cmp($sformatf("step%0d_changes", s), n_changes, tbl[s].exp_changes);
    end
  endtask

  // Scoreboard: every change pulse consumes one expected lock entry
  always @(negedge clk) begin
    if (change) begin
      n_changes++;
      cmp("chg_while_locked", int'(locked), 1);
      cmp("chg_single_cycle", int'(chg_prev), 0);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL chg_unexpected: change pulse with no lock expected (rate %0d fam %0d)", rate, fam_48);
      end else begin
        lock_t e;
        e = exp_q.pop_front();
        cmp("chg_rate", int'(rate), int'(e.rate));
        cmp("chg_fam48", int'(fam_48), int'(e.fam));
        cmp_tol("chg_period", int'(period), e.period, e.tol);
      end
    end
    chg_prev = change;
  end

  initial begin
    int cyc;
    //               t     n  mode push lk  rate   fam per   tol chg
    tbl[0]  = mk(1042, 4, 0, 1'b0, 1'b0, 2'b00, 1'b0, 1042, 0, 0);
    tbl[1]  = mk( 521, 4, 0, 1'b0, 1'b1, 2'b00, 1'b1,  521, 0, 1);
    tbl[2]  = mk( 521, 1, 0, 1'b0, 1'b0, 2'b00, 1'b1,  521, 0, 1);
    tbl[3]  = mk( 521, 4, 0, 1'b1, 1'b1, 2'b01, 1'b1,  521, 0, 2);
    tbl[4]  = mk( 283, 4, 1, 1'b0, 1'b1, 2'b01, 1'b1,  283, 1, 2);
    tbl[5]  = mk( 283, 1, 1, 1'b0, 1'b0, 2'b01, 1'b1,  283, 1, 2);
    tbl[6]  = mk( 283, 4, 1, 1'b1, 1'b1, 2'b10, 1'b0,  283, 1, 3);
    tbl[7]  = mk( 700, 5, 0, 1'b0, 1'b0, 2'b10, 1'b0,  700, 0, 3);
    tbl[8]  = mk(1133, 5, 2, 1'b1, 1'b1, 2'b00, 1'b0, 1133, 20, 4);
    tbl[9]  = mk( 130, 5, 0, 1'b0, 1'b0, 2'b00, 1'b0,  130, 0, 4);
    tbl[10] = mk( 130, 4, 0, 1'b1, 1'b1, 2'b11, 1'b1,  130, 0, 5);
    tbl[11] = mk( 130, 8, 3, 1'b0, 1'b1, 2'b11, 1'b1,  700, 0, 5);
    tbl[12] = mk( 260, 4, 0, 1'b0, 1'b0, 2'b11, 1'b1,  260, 0, 5);
    tbl[13] = mk( 260, 1, 0, 1'b1, 1'b1, 2'b10, 1'b1,  260, 0, 6);
    tbl[14] = mk( 260, 4, 0, 1'b0, 1'b0, 2'b00, 1'b0,  260, 0, 6);
    tbl[15] = mk( 260, 1, 0, 1'b1, 1'b1, 2'b10, 1'b1,  260, 0, 7);

    resetn = 1'b0;
    lrck   = 1'b0;
    repeat (3) @(negedge clk);
    cmp("rst_rate", int'(rate), 0);
    cmp("rst_fam48", int'(fam_48), 0);
    cmp("rst_locked", int'(locked), 0);
    cmp("rst_change", int'(change), 0);
    cmp("rst_period", int'(period), 0);
    resetn = 1'b1;
    @(negedge clk);

    // 48 kHz: four frames, then the fifth edge locks three cycles after it is sampled
    run_steps(0, 0);
    exp_q.push_back(mk_lock(2'b00, 1'b1, 1042, 0));
    lrck = 1'b1;
    repeat (3) @(negedge clk);
    cmp("lat_locked_early", int'(locked), 0);
    @(negedge clk);
    cmp("lat_locked", int'(locked), 1);
    cmp("lat_change", int'(change), 1);
    cmp("lat_rate", int'(rate), 0);
    cmp("lat_fam48", int'(fam_48), 1);
    cmp("lat_period", int'(period), 1042);
    @(negedge clk);
    cmp("lat_change_off", int'(change), 0);
    repeat (521 - 5) @(negedge clk);
    lrck = 1'b0;
    repeat (521) @(negedge clk);

    // rate switch, 176.4k, invalid period, 44.1k jitter, 384k, glitches while locked
    run_steps(1, 11);

    // LRCK stops after one more edge: lock must drop exactly at the timeout
    lrck = 1'b1;
    cyc  = 0;
    while (locked && (cyc < 70000)) begin
      @(negedge clk);
      cyc++;
      if (cyc == 65) lrck = 1'b0;
    end
    cmp("stop_latency", cyc, 65539);
    cmp("stop_rate", int'(rate), 3);
    cmp("stop_fam48", int'(fam_48), 1);
    cmp("stop_period", int'(period), 130);

    // restart from idle needs five edges
    run_steps(12, 13);

    // asynchronous reset while locked, then a fresh five-edge acquisition
    @(negedge clk);
    #3 resetn = 1'b0;
    #1;
    cmp("arst_rate", int'(rate), 0);
    cmp("arst_fam48", int'(fam_48), 0);
    cmp("arst_locked", int'(locked), 0);
    cmp("arst_change", int'(change), 0);
    cmp("arst_period", int'(period), 0);
    @(negedge clk);
    @(negedge clk);
    #3 resetn = 1'b1;
    @(negedge clk);
    run_steps(14, 15);

    cmp("sb_leftover", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
